// File: rtl/mul_div_pkg.sv
// mul_div_pkg
// Shared definitions for the multiply/divide unit: operation encodings,
// FSM state type and small op-decode helpers.
package mul_div_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Bit 1 of the op code selects divide, bit 0 selects signed operands.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/mul_div_cond_neg.sv
// mul_div_cond_neg
// Conditional two's-complement negate. Used both to take operand
// magnitudes and to apply the result sign after the unsigned core.
// Ports:
//   a   in  W  value
//   neg in  1  1 = output -a, 0 = output a
//   y   out W  result
module mul_div_cond_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Multiply is shift-add (one multiplier bit per cycle), divide is
// restoring (one quotient bit per cycle). Signed ops run on magnitudes
// and the sign is applied in the FIX cycle.
// Optional feature: define MUL_DIV_EARLY_TERM_EN to let a multiply leave
// CALC as soon as the remaining multiplier bits are all zero.
// Ports:
//   clk_i          in  1      clock, rising edge
//   rst_i          in  1      asynchronous active-low reset
//   start_i        in  1      begin operation (sampled in IDLE only)
//   op_i           in  2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   src1_i         in  WIDTH  multiplicand / dividend
//   src2_i         in  WIDTH  multiplier / divisor
//   hi_we_i        in  1      MTHI strobe (IDLE only)
//   lo_we_i        in  1      MTLO strobe (IDLE only)
//   wdata_i        in  WIDTH  MTHI/MTLO data
//   busy_o         out 1      operation in flight
//   done_o         out 1      one-cycle pulse, HI/LO just updated
//   div_by_zero_o  out 1      pulses with done_o on a zero divisor
//   hi_o, lo_o     out WIDTH  HI / LO registers
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_by_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e               state_reg;
  logic                 is_div_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2*WIDTH-1:0]   acc_reg;    // mult: product; div: {remainder, quotient}
  logic [2*WIDTH-1:0]   mcand_reg;  // mult: multiplicand, shifted left each step
  logic [WIDTH-1:0]     b_reg;      // mult: remaining multiplier; div: divisor
  logic                 neg_q_reg;
  logic                 neg_r_reg;
  logic                 dbz_reg;
  logic [WIDTH-1:0]     hi_reg;
  logic [WIDTH-1:0]     lo_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 dbz_out_reg;

  // Operand magnitudes (raw values for unsigned ops).
  logic             sgn;
  logic [WIDTH-1:0] abs1;
  logic [WIDTH-1:0] abs2;

  assign sgn = op_is_signed(op_i);

  mul_div_cond_neg #(.W(WIDTH)) u_abs1 (
    .a(src1_i), .neg(sgn & src1_i[WIDTH-1]), .y(abs1)
  );
  mul_div_cond_neg #(.W(WIDTH)) u_abs2 (
    .a(src2_i), .neg(sgn & src2_i[WIDTH-1]), .y(abs2)
  );

  // Restoring divide step. The bit shifted out of the top of the
  // remainder is kept as a carry so the trial compare is WIDTH+1 bits.
  logic [2*WIDTH-1:0] div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign div_shift = {acc_reg[2*WIDTH-2:0], 1'b0};
  assign div_ge    = {acc_reg[2*WIDTH-1], div_shift[2*WIDTH-1:WIDTH]} >= {1'b0, b_reg};
  assign div_next  = div_ge ? {div_shift[2*WIDTH-1:WIDTH] - b_reg, div_shift[WIDTH-1:1], 1'b1}
                            : div_shift;

  // Shift-add multiply step.
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   b_shift_next;

  assign mul_next     = b_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign b_shift_next = b_reg >> 1;

  // Once no multiplier bits remain, further steps add nothing, so the
  // counter may be cleared and the product is already final.
  logic early_next;
`ifdef MUL_DIV_EARLY_TERM_EN
  assign early_next = ~is_div_reg & (b_shift_next == '0);
`else
  assign early_next = 1'b0;
`endif

  // Result sign fix-up.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  mul_div_cond_neg #(.W(2*WIDTH)) u_fix_prod (
    .a(acc_reg), .neg(neg_q_reg), .y(prod_fix)
  );
  mul_div_cond_neg #(.W(WIDTH)) u_fix_quo (
    .a(acc_reg[WIDTH-1:0]), .neg(neg_q_reg), .y(quo_fix)
  );
  mul_div_cond_neg #(.W(WIDTH)) u_fix_rem (
    .a(acc_reg[2*WIDTH-1:WIDTH]), .neg(neg_r_reg), .y(rem_fix)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= IDLE;
      is_div_reg  <= 1'b0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      b_reg       <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      dbz_reg     <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      dbz_out_reg <= 1'b0;
    end else begin
      done_reg    <= 1'b0;
      dbz_out_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            is_div_reg <= op_is_div(op_i);
            neg_q_reg  <= sgn & (src1_i[WIDTH-1] ^ src2_i[WIDTH-1]);
            neg_r_reg  <= sgn & src1_i[WIDTH-1];
            dbz_reg    <= op_is_div(op_i) & (src2_i == '0);
            cnt_reg    <= CNT_W'(WIDTH);
            b_reg      <= abs2;
            busy_reg   <= 1'b1;
            state_reg  <= CALC;
            if (op_is_div(op_i)) begin
              acc_reg   <= {{WIDTH{1'b0}}, abs1};
              mcand_reg <= '0;
            end else begin
              acc_reg   <= '0;
              mcand_reg <= {{WIDTH{1'b0}}, abs1};
            end
          end else begin
            // Start wins over MTHI/MTLO in the same cycle.
            if (hi_we_i) hi_reg <= wdata_i;
            if (lo_we_i) lo_reg <= wdata_i;
          end
        end
        CALC: begin
          if (cnt_reg == '0) begin
            state_reg <= FIX;
          end else begin
            if (is_div_reg) begin
              acc_reg <= div_next;
            end else begin
              acc_reg   <= mul_next;
              mcand_reg <= mcand_reg << 1;
              b_reg     <= b_shift_next;
            end
            cnt_reg <= early_next ? '0 : cnt_reg - CNT_W'(1);
          end
        end
        FIX: begin
          if (is_div_reg) begin
            // A zero divisor leaves the remainder equal to the dividend,
            // so HI already holds the original src1; LO is forced to ones.
            hi_reg <= rem_fix;
            lo_reg <= dbz_reg ? {WIDTH{1'b1}} : quo_fix;
          end else begin
            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
            lo_reg <= prod_fix[WIDTH-1:0];
          end
          busy_reg    <= 1'b0;
          done_reg    <= 1'b1;
          dbz_out_reg <= dbz_reg;
          state_reg   <= DONE;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_reg;
  assign done_o        = done_reg;
  assign div_by_zero_o = dbz_out_reg;
  assign hi_o          = hi_reg;
  assign lo_o          = lo_reg;

endmodule
